// File: rtl/cond_unit_it.sv
// Registered N/Z/C/V condition unit with gated PCSrc/RegWrite/MemWrite and an IT-block sequencer.
// Define COND_UNIT_IT_EN to build the IT sequencer; without it every instruction is evaluated on Cond.
module cond_unit_it #(
    parameter  int IT_DEPTH = 4,
    localparam int LW       = $clog2(IT_DEPTH + 1),
    localparam int MW       = (IT_DEPTH > 1) ? IT_DEPTH - 1 : 1
) (
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          InstrValid,
    input  logic [3:0]    Cond,
    input  logic [3:0]    ALUFlags,
    input  logic [1:0]    FlagW,
    input  logic          PCS,
    input  logic          RegW,
    input  logic          MemW,
    input  logic          ITStart,
    input  logic [3:0]    ITFirstCond,
    input  logic [MW-1:0] ITMask,
    input  logic [LW-1:0] ITLen,
    output logic          PCSrc,
    output logic          RegWrite,
    output logic          MemWrite,
    output logic          CondEx,
    output logic [3:0]    Flags,
    output logic          InIT,
    output logic [LW-1:0] ITRemain,
    output logic          ITError
);

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        logic res;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h0:    res = z;
            4'h1:    res = ~z;
            4'h2:    res = cf;
            4'h3:    res = ~cf;
            4'h4:    res = n;
            4'h5:    res = ~n;
            4'h6:    res = v;
            4'h7:    res = ~v;
            4'h8:    res = cf & ~z;
            4'h9:    res = ~cf | z;
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = ~z & (n == v);
            4'hD:    res = z | (n != v);
            4'hE:    res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [3:0] flags_q, flags_d;
    logic       cond_ex;
    // High for the IT instruction itself: it passes but must not write anything.
    logic       suppress;

`ifdef COND_UNIT_IT_EN
    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    first_q, first_d;
    logic [MW-1:0] mask_q, mask_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] remain_q, remain_d;
    logic [LW-1:0] slot_idx;
    logic [3:0]    slot_cond;
    logic          len_ok;
    logic          it_error;
    logic [3:0]    slot_cond_arr [IT_DEPTH];

    // Slot k>=1 flips the low condition bit on an 'else' mask bit; an AL block stays AL throughout.
    assign slot_cond_arr[0] = first_q;
    generate
        for (genvar gi = 1; gi < IT_DEPTH; gi++) begin : g_slot
            assign slot_cond_arr[gi] = (first_q == 4'hE) ? 4'hE
                                     : {first_q[3:1], mask_q[gi-1] ? first_q[0] : ~first_q[0]};
        end
    endgenerate

    assign slot_idx = len_q - remain_q;
    assign len_ok   = (ITLen != '0) && (ITLen <= LW'(IT_DEPTH));

    always_comb begin
        slot_cond = first_q;
        for (int i = 0; i < IT_DEPTH; i++) begin
            if (slot_idx == LW'(i)) begin
                slot_cond = slot_cond_arr[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        mask_d   = mask_q;
        len_d    = len_q;
        remain_d = remain_q;
        cond_ex  = cond_eval(Cond, flags_q);
        suppress = 1'b0;
        it_error = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ITStart) begin
                    cond_ex  = 1'b1;
                    suppress = 1'b1;
                    it_error = InstrValid & ~len_ok;
                    if (InstrValid && len_ok) begin
                        state_d  = ST_ACTIVE;
                        first_d  = ITFirstCond;
                        mask_d   = ITMask;
                        len_d    = ITLen;
                        remain_d = ITLen;
                    end
                end
            end
            ST_ACTIVE: begin
                // A nested IT is rejected but still consumes its slot.
                cond_ex  = ITStart ? 1'b0 : cond_eval(slot_cond, flags_q);
                it_error = InstrValid & ITStart;
                if (InstrValid) begin
                    remain_d = remain_q - LW'(1);
                    if ((remain_q == LW'(1)) || (PCS && cond_ex)) begin
                        state_d  = ST_IDLE;
                        remain_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            first_q  <= '0;
            mask_q   <= '0;
            len_q    <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            mask_q   <= mask_d;
            len_q    <= len_d;
            remain_q <= remain_d;
        end
    end

    assign InIT     = (state_q == ST_ACTIVE);
    assign ITRemain = remain_q;
    assign ITError  = it_error;
`else
    logic unused_it;

    assign unused_it = ^{ITStart, ITFirstCond, ITMask, ITLen};
    assign cond_ex   = cond_eval(Cond, flags_q);
    assign suppress  = 1'b0;
    assign InIT      = 1'b0;
    assign ITRemain  = '0;
    assign ITError   = 1'b0;
`endif

    always_comb begin
        flags_d = flags_q;
        if (InstrValid && cond_ex && !suppress) begin
            if (FlagW[1]) begin
                flags_d[3:2] = ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                flags_d[1:0] = ALUFlags[1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign CondEx   = cond_ex;
    assign Flags    = flags_q;
    assign PCSrc    = PCS  & cond_ex & InstrValid & ~suppress;
    assign RegWrite = RegW & cond_ex & InstrValid & ~suppress;
    assign MemWrite = MemW & cond_ex & InstrValid & ~suppress;

endmodule

// File: doc/cond_unit_it.md
# cond_unit_it

Registered condition unit for the processor's execute stage, successor to the combinational condition check. Holds the architectural N/Z/C/V flags, evaluates each instruction's 4-bit condition against them, and gates PCSrc/RegWrite/MemWrite. Adds a parametrised IT-block (If-Then) sequencer that predicates up to IT_DEPTH following instructions from a single IT instruction.

## Interface
- IT_DEPTH, 4, maximum instructions in one IT block; legal range 1..8.
- LW, $clog2(IT_DEPTH+1), width of length/remaining-count fields (derived, not overridden).

- CLK  input  1  clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- InstrValid  input  1  an instruction occupies the stage this cycle.
- Cond  input  4  condition field of the instruction.
- ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  input  2  [1]: write N,Z; [0]: write C,V.
- PCS, RegW, MemW  input  1 each  ungated decoder controls.
- ITStart  input  1  instruction is an IT instruction.
- ITFirstCond  input  4  base condition of the IT block.
- ITMask  input  IT_DEPTH-1  then/else mask for slots 1..IT_DEPTH-1.
- ITLen  input  LW  number of predicated instructions.
- PCSrc, RegWrite, MemWrite  output  1 each  gated controls.
- CondEx  output  1  effective condition passed.
- Flags  output  4  registered {N,Z,C,V}.
- InIT  output  1  IT block active.
- ITRemain  output  LW  slots left in the active block.
- ITError  output  1  malformed/nested IT this cycle (combinational).

## Operation
- Condition encoding 0000..1110 is EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; 1111 evaluates false.
- Evaluation uses registered Flags, never ALUFlags.
- Effective condition: IDLE uses Cond. IT_ACTIVE slot k (k = ITLen_stored − ITRemain) uses stored FirstCond for k=0; for k≥1 uses {FirstCond[3:1], Mask[k-1] ? FirstCond[0] : ~FirstCond[0]}. If FirstCond=1110, every slot is AL regardless of mask.
- Gated outputs = ungated & CondEx & InstrValid.
- Flag update: on edge with InstrValid & CondEx, N,Z ← ALUFlags[3:2] if FlagW[1]; C,V ← ALUFlags[1:0] if FlagW[0].
- States IDLE, IT_ACTIVE.
- IDLE + InstrValid + ITStart, 1 ≤ ITLen ≤ IT_DEPTH: store FirstCond/Mask/ITLen, ITRemain ← ITLen, → IT_ACTIVE. IT instruction: CondEx=1, PCSrc/RegWrite/MemWrite=0, no flag write; Cond ignored.
- IDLE + ITStart with ITLen=0 or >IT_DEPTH: ITError=1, stay IDLE, treated as the same no-op.
- IT_ACTIVE + InstrValid: ITRemain decrements; reaching 0 → IDLE. PCSrc=1 in any slot ends the block immediately (→ IDLE, ITRemain ← 0).
- IT_ACTIVE + ITStart (nested): ITError=1, CondEx=0, all writes suppressed, slot consumed as normal.
- InstrValid=0: no flag or state change; CondEx still reflects evaluation.

## Timing
- CondEx and gated outputs combinational from inputs, state and Flags; same cycle.
- Flags and state update on rising CLK; flag written by instruction n visible to instruction n+1 in the next valid cycle.
- First predicated slot is the InstrValid cycle after the IT instruction.
- Reset (any time, including mid-block): Flags=0000, IDLE, InIT=0, ITRemain=0, stored FirstCond/Mask/Len=0; gated outputs follow reset state combinationally.

## Configuration
- COND_UNIT_IT_EN defined: IT sequencer as above.
- Undefined: no state machine; ITStart/ITFirstCond/ITMask/ITLen ignored, every instruction uses Cond; InIT=0, ITRemain=0, ITError=0. Flag register and gating unchanged.

## Test plan
- Reset, Cond=0000 (EQ), RegW=1 → RegWrite=0 (Z=0); ALUFlags=0100, FlagW=10, Cond=1110 → next cycle Flags=0100, EQ gives RegWrite=1.
- Flags=1001 (N=1,V=1): Cond=1010 (GE) → CondEx=1; Cond=1011 (LT) → 0; Cond=1111 → 0.
- IT_DEPTH=4, ITFirstCond=0000, ITMask=3'b010, ITLen=4, Z=1: slots give CondEx 1,0,1,0; ITRemain 4,3,2,1; IDLE after slot 3.
- ITLen=0 → ITError=1, InIT stays 0; ITStart in slot 1 of active block → ITError=1, CondEx=0, ITRemain still decrements.
- Slot 0 of 3-slot block with PCS=1, condition true → PCSrc=1, next cycle InIT=0, ITRemain=0.
- Reset_n low mid-block (ITRemain=2) → InIT=0, Flags=0000 immediately; macro undefined → ITStart with ITLen=2 has no effect, CondEx follows Cond.
